// File: rtl/memory_sp_ctrl.sv
// Single-port memory controller: request pass-through to the memory plus an in-order read-response
// buffer. Define MEMORY_SP_CTRL_RDBUF2_EN for a 2-entry response FIFO (default: 1 entry).
module memory_sp_ctrl #(
  parameter int unsigned DW    = 104,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nreset,
  // request channel
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wem,
  input  logic [DW-1:0] req_din,
  // read-response channel
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  // memory port
  output logic          mem_en,
  output logic          mem_we,
  output logic [DW-1:0] mem_wem,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  // status
  output logic          busy,
  output logic [15:0]   rd_count
);

`ifdef MEMORY_SP_CTRL_RDBUF2_EN
  localparam int unsigned C = 2;
`else
  localparam int unsigned C = 1;
`endif

  logic          inflight_q, inflight_d;
  logic [AW-1:0] inflight_addr_q, inflight_addr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [15:0]   rd_count_q, rd_count_d;
  logic [1:0]    occ;
  logic          accept, rd_accept, push, pop;

  // Credit check uses registered occupancy only, so req_ready never depends on rsp_ready.
  assign occ       = {1'b0, inflight_q} + cnt_q;
  assign req_ready = (occ < 2'(C));
  assign accept    = req_valid & req_ready;
  assign rd_accept = accept & ~req_write;
  assign push      = inflight_q;
  assign pop       = rsp_valid & rsp_ready;

  assign mem_en    = accept;
  assign mem_we    = req_write;
  assign mem_addr  = req_addr;
  assign mem_wem   = req_wem;
  assign mem_din   = req_din;

  assign rsp_valid = (cnt_q != 2'd0);
  assign busy      = (occ != 2'd0);
  assign rd_count  = rd_count_q;

  always_comb begin
    inflight_d      = rd_accept;
    inflight_addr_d = rd_accept ? req_addr : inflight_addr_q;
    cnt_d           = cnt_q + {1'b0, push} - {1'b0, pop};
    rd_count_d      = rd_count_q + {15'd0, pop};
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      cnt_q           <= 2'd0;
      rd_count_q      <= 16'd0;
    end else begin
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      cnt_q           <= cnt_d;
      rd_count_q      <= rd_count_d;
    end
  end

`ifdef MEMORY_SP_CTRL_RDBUF2_EN
  logic [DW-1:0] data_q [2];
  logic [AW-1:0] addr_q [2];
  logic          wptr_q, rptr_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wptr_q] <= mem_dout;
      addr_q[wptr_q] <= inflight_addr_q;
    end
  end

  assign rsp_data = data_q[rptr_q];
  assign rsp_addr = addr_q[rptr_q];
`else
  logic [DW-1:0] data_q;
  logic [AW-1:0] addr_q;

  // With one entry a push only happens while the buffer is empty, so no pop can coincide.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q <= mem_dout;
      addr_q <= inflight_addr_q;
    end
  end

  assign rsp_data = data_q;
  assign rsp_addr = addr_q;
`endif

`ifndef SYNTHESIS
  push_when_full_a: assert property (@(posedge clk) disable iff (!nreset)
    !(push && (cnt_q == 2'(C))));
`endif

endmodule
